// File: rtl/riscv_operand_fetch.sv
// Two-operand register file fetch with x0 masking and writeback hazard handling.
// Build option OPFETCH_BYPASS_EN: forward writebacks into the operands instead of replaying the read.
module riscv_operand_fetch #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rs1_data,
    output logic [DATA_WIDTH-1:0] rsp_rs2_data,
    output logic                  rf_rd1_en,
    output logic                  rf_rd2_en,
    output logic [ADDR_WIDTH-1:0] rf_rd1_addr,
    output logic [ADDR_WIDTH-1:0] rf_rd2_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd1_data,
    input  logic [DATA_WIDTH-1:0] rf_rd2_data,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rs1_idx_p1;
    logic [ADDR_WIDTH-1:0]   rs2_idx_p1;
    logic                    hit1_p1;
    logic                    hit2_p1;
`ifdef OPFETCH_BYPASS_EN
    logic [DATA_WIDTH-1:0]   fwd1_p1;
    logic [DATA_WIDTH-1:0]   fwd2_p1;
`endif

    logic                    wb_nz;
    logic [ADDR_WIDTH-1:0]   rd1_idx;
    logic [ADDR_WIDTH-1:0]   rd2_idx;
    logic                    rhit1;
    logic                    rhit2;
    logic                    accept;
    logic                    replay;
    logic                    vld_p0;

    // x0 always reads as zero; a same-cycle writeback beats an earlier forwarded value.
    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic                  rhit,
        input logic                  ihit,
        input logic [DATA_WIDTH-1:0] wbd,
        input logic [DATA_WIDTH-1:0] fwd,
        input logic [DATA_WIDTH-1:0] rfd
    );
        if (idx == '0) begin
            return '0;
        end else if (rhit) begin
            return wbd;
        end else if (ihit) begin
            return fwd;
        end
        return rfd;
    endfunction

    // Stage p0: read issue, either a fresh request in IDLE or a replay in READ
    always_comb begin
        wb_nz   = wb_valid && (wb_addr != '0);
        rd1_idx = (state == IDLE) ? req_rs1 : rs1_idx_p1;
        rd2_idx = (state == IDLE) ? req_rs2 : rs2_idx_p1;
        rhit1   = wb_nz && (wb_addr == rd1_idx);
        rhit2   = wb_nz && (wb_addr == rd2_idx);
        accept  = rst_n && (state == IDLE) && req_valid;
`ifdef OPFETCH_BYPASS_EN
        replay  = 1'b0;
`else
        replay  = (state == READ) && (hit1_p1 || hit2_p1 || rhit1 || rhit2);
`endif
        vld_p0  = accept || (rst_n && replay);
    end

    assign req_ready   = rst_n && (state == IDLE);
    assign rf_rd1_en   = vld_p0;
    assign rf_rd2_en   = vld_p0;
    assign rf_rd1_addr = rd1_idx;
    assign rf_rd2_addr = rd2_idx;

    assign rf_wr_en    = rst_n && wb_nz;
    assign rf_wr_addr  = wb_addr;
    assign rf_wr_data  = wb_data;

    // Stage p1: READ capture into the held response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
            rs1_idx_p1   <= '0;
            rs2_idx_p1   <= '0;
            hit1_p1      <= 1'b0;
            hit2_p1      <= 1'b0;
`ifdef OPFETCH_BYPASS_EN
            fwd1_p1      <= '0;
            fwd2_p1      <= '0;
`endif
        end else begin
            hit1_p1 <= vld_p0 && rhit1;
            hit2_p1 <= vld_p0 && rhit2;
`ifdef OPFETCH_BYPASS_EN
            if (vld_p0) begin
                fwd1_p1 <= wb_data;
                fwd2_p1 <= wb_data;
            end
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rs1_idx_p1 <= req_rs1;
                        rs2_idx_p1 <= req_rs2;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (!replay) begin
`ifdef OPFETCH_BYPASS_EN
                        rsp_rs1_data <= pick_operand(rs1_idx_p1, rhit1, hit1_p1,
                                                     wb_data, fwd1_p1, rf_rd1_data);
                        rsp_rs2_data <= pick_operand(rs2_idx_p1, rhit2, hit2_p1,
                                                     wb_data, fwd2_p1, rf_rd2_data);
`else
                        rsp_rs1_data <= pick_operand(rs1_idx_p1, 1'b0, 1'b0,
                                                     wb_data, {DATA_WIDTH{1'b0}}, rf_rd1_data);
                        rsp_rs2_data <= pick_operand(rs2_idx_p1, 1'b0, 1'b0,
                                                     wb_data, {DATA_WIDTH{1'b0}}, rf_rd2_data);
`endif
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Bench for riscv_operand_fetch: behavioural register file, vector table and hazard/reset sequences,
// with a response scoreboard checking operand data and request-to-response latency.
module tb_riscv_operand_fetch;

    localparam int DW = 64;
    localparam int AW = 5;

`ifdef OPFETCH_BYPASS_EN
    localparam int   LAT_ISSUE_HIT = 2;
    localparam int   LAT_DOUBLE    = 2;
    localparam logic RD_IN_READ    = 1'b0;
`else
    localparam int   LAT_ISSUE_HIT = 3;
    localparam int   LAT_DOUBLE    = 4;
    localparam logic RD_IN_READ    = 1'b1;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rs1_data;
    logic [DW-1:0] rsp_rs2_data;
    logic          rf_rd1_en;
    logic          rf_rd2_en;
    logic [AW-1:0] rf_rd1_addr;
    logic [AW-1:0] rf_rd2_addr;
    logic [DW-1:0] rf_rd1_data;
    logic [DW-1:0] rf_rd2_data;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;

    riscv_operand_fetch #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rs1_data(rsp_rs1_data),
        .rsp_rs2_data(rsp_rs2_data),
        .rf_rd1_en   (rf_rd1_en),
        .rf_rd2_en   (rf_rd2_en),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_rd2_addr (rf_rd2_addr),
        .rf_rd1_data (rf_rd1_data),
        .rf_rd2_data (rf_rd2_data),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous read (data one cycle after enable), old value on same-cycle write.
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (bd_we) rf[bd_addr] <= bd_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        if (rf_rd1_en) rf_rd1_data <= rf[rf_rd1_addr];
        if (rf_rd2_en) rf_rd2_data <= rf[rf_rd2_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    typedef struct {
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        int            acc;
        int            lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;
    vec_t vecs[7];

    // Response monitor: first-high latency and handshake data against the scoreboard head.
    logic vld_d = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_d <= 1'b0;
        end else begin
            if (rsp_valid && !vld_d) begin
                if (sb.size() == 0) fail_now("unexpected_rsp_valid");
                else check("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_handshake");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rs1_data", rsp_rs1_data, e.e1);
                    check("rsp_rs2_data", rsp_rs2_data, e.e2);
                end
            end
            vld_d <= rsp_valid;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        next_cycle();
        bd_we   = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2, input int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            next_cycle();
            n++;
        end
        if (!req_ready) begin
            fail_now("req_ready_timeout");
            return;
        end
        req_valid = 1'b1;
        req_rs1   = r1;
        req_rs2   = r2;
        sb.push_back('{e1, e2, cyc, lat});
        #1;
        check("issue_rd1_en", 64'(rf_rd1_en), 64'(1));
        check("issue_rd2_en", 64'(rf_rd2_en), 64'(1));
        check("issue_rd1_addr", 64'(rf_rd1_addr), 64'(r1));
        check("issue_rd2_addr", 64'(rf_rd2_addr), 64'(r2));
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 60) begin
            next_cycle();
            n++;
        end
        if (sb.size() != 0 || !req_ready) begin
            fail_now("drain_timeout");
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0] = '{5'd5,  5'd6,  64'h11, 64'h22};
        vecs[1] = '{5'd6,  5'd5,  64'h22, 64'h11};
        vecs[2] = '{5'd0,  5'd5,  64'h0,  64'h11};
        vecs[3] = '{5'd10, 5'd31, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{5'd31, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[5] = '{5'd7,  5'd7,  64'h77, 64'h77};
        vecs[6] = '{5'd0,  5'd0,  64'h0,  64'h0};

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd6;
        rsp_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 64'h5A;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        #2;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rs1_data", rsp_rs1_data, 64'h0);
        check("reset_rs2_data", rsp_rs2_data, 64'h0);
        check("reset_rd1_en", 64'(rf_rd1_en), 64'(0));
        check("reset_rd2_en", 64'(rf_rd2_en), 64'(0));
        check("reset_wr_en", 64'(rf_wr_en), 64'(0));
        req_valid = 1'b0;
        wb_valid  = 1'b0;

        next_cycle();
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] v;
            case (i)
                0:       v = 64'hFF;
                5:       v = 64'h11;
                6:       v = 64'h22;
                7:       v = 64'h77;
                10:      v = 64'hDEAD_BEEF_0123_4567;
                31:      v = 64'hFFFF_FFFF_FFFF_FFFF;
                default: v = 64'h1000 + 64'(i);
            endcase
            bd_write(AW'(i), v);
        end
        rst_n = 1'b1;
        #1;
        check("post_reset_req_ready", 64'(req_ready), 64'(1));
        check("post_reset_idle_rd_en", 64'(rf_rd1_en), 64'(0));
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].rs1, vecs[i].rs2, vecs[i].e1, vecs[i].e2, 2);
            check("read_req_ready", 64'(req_ready), 64'(0));
            wait_idle();
        end

        // x0 request while writeback targets x0 in both the issue and READ cycles
        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 64'h33;
        #1;
        check("x0_wb_wr_en", 64'(rf_wr_en), 64'(0));
        issue(5'd0, 5'd0, 64'h0, 64'h0, 2);
        check("x0_wb_wr_en_read", 64'(rf_wr_en), 64'(0));
        next_cycle();
        wb_valid = 1'b0;
        wait_idle();

        // Writeback to x7 in the issue cycle
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 64'hAB;
        #1;
        check("wb_wr_en", 64'(rf_wr_en), 64'(1));
        check("wb_wr_addr", 64'(rf_wr_addr), 64'(7));
        check("wb_wr_data", rf_wr_data, 64'hAB);
        issue(5'd7, 5'd5, 64'hAB, 64'h11, LAT_ISSUE_HIT);
        wb_valid = 1'b0;
        #1;
        check("issue_hit_read_rd_en", 64'(rf_rd1_en), 64'(RD_IN_READ));
        wait_idle();

        // Writebacks to x7 in both the issue cycle and the READ cycle: newest value wins
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 64'h01;
        issue(5'd7, 5'd6, 64'h02, 64'h22, LAT_DOUBLE);
        wb_data  = 64'h02;
        #1;
        check("double_hit_read_rd_en", 64'(rf_rd1_en), 64'(RD_IN_READ));
        next_cycle();
        wb_valid = 1'b0;
        wait_idle();

        // Response back-pressure with a writeback to x5 while the response is held
        rsp_ready = 1'b0;
        issue(5'd5, 5'd6, 64'h11, 64'h22, 2);
        n = 0;
        while (!rsp_valid && n < 20) begin
            next_cycle();
            n++;
        end
        if (!rsp_valid) fail_now("hold_rsp_valid_timeout");
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 64'h99;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            check("hold_rs1_data", rsp_rs1_data, 64'h11);
            check("hold_rs2_data", rsp_rs2_data, 64'h22);
            check("hold_req_ready", 64'(req_ready), 64'(0));
            check("hold_rd1_en", 64'(rf_rd1_en), 64'(0));
            next_cycle();
        end
        wb_valid  = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset asserted while the request sits in READ: it must vanish without a response
        issue(5'd6, 5'd7, 64'h22, 64'h02, 2);
        rst_n     = 1'b0;
        req_valid = 1'b1;
        wb_valid  = 1'b1;
        wb_addr   = 5'd9;
        wb_data   = 64'h44;
        #1;
        sb.delete();
        check("rst_read_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_read_rs1_data", rsp_rs1_data, 64'h0);
        check("rst_read_rd1_en", 64'(rf_rd1_en), 64'(0));
        check("rst_read_rd2_en", 64'(rf_rd2_en), 64'(0));
        check("rst_read_wr_en", 64'(rf_wr_en), 64'(0));
        next_cycle();
        next_cycle();
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("rst_release_req_ready", 64'(req_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check("rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        issue(5'd6, 5'd5, 64'h22, 64'h99, 2);
        wait_idle();

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
